// File: rtl/ram_nr1w_byte_en.sv
// Multi-read, single-write RAM with per-byte write enables and a zeroing sweep after reset.
// Define RAM_NR1W_BYPASS_EN for write-first collisions; the default build is read-first.
module ram_nr1w_byte_en #(
    parameter int WIDTH    = 64,
    parameter int LG_DEPTH = 6,
    parameter int NUM_RD   = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD*LG_DEPTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    input  logic [LG_DEPTH-1:0]        wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_en,
    input  logic [WIDTH/8-1:0]         wr_byte_en,
    output logic                       init_busy
);

    localparam int DEPTH     = 1 << LG_DEPTH;
    localparam int NUM_BYTES = WIDTH / 8;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LG_DEPTH-1:0] counter;
    logic [LG_DEPTH-1:0] counter_next;
    logic [WIDTH-1:0]    mem     [DEPTH];
    logic [WIDTH-1:0]    rd_word [NUM_RD];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            counter   <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            init_busy <= (state_next == ST_INIT);
        end
    end

    // The sweep leaves INIT on the same edge that clears the last entry.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        if (state == ST_INIT) begin
            counter_next = counter + LG_DEPTH'(1);
            if (&counter) begin
                state_next = ST_READY;
            end
        end
    end

    // The array has no reset; the sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[counter] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_byte_en[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_word[p] = mem[rd_addr[p*LG_DEPTH +: LG_DEPTH]];
`ifdef RAM_NR1W_BYPASS_EN
            if (wr_en && (state == ST_READY) &&
                (rd_addr[p*LG_DEPTH +: LG_DEPTH] == wr_addr)) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_byte_en[b]) begin
                        rd_word[p][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data[p*WIDTH +: WIDTH] <= (state == ST_READY) ? rd_word[p] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_nr1w_byte_en.sv
// Self-checking bench for ram_nr1w_byte_en: sweep timing, byte-masked writes,
// collisions and randomized traffic against an array model of the memory.
module tb_ram_nr1w_byte_en;

    localparam int WIDTH    = 64;
    localparam int LG_DEPTH = 6;
    localparam int NUM_RD   = 2;
    localparam int DEPTH    = 64;
    localparam int NB       = WIDTH / 8;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [NUM_RD*LG_DEPTH-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]    rd_data;
    logic [LG_DEPTH-1:0]        wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic                       wr_en;
    logic [NB-1:0]              wr_byte_en;
    logic                       init_busy;

    logic [WIDTH-1:0] model [DEPTH];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_nr1w_byte_en #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_byte_en (wr_byte_en),
        .init_busy  (init_busy)
    );

    function automatic logic [WIDTH-1:0] byte_mask(input logic [NB-1:0] be);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Value a port should show after an edge that reads addr while this write happens.
    function automatic logic [WIDTH-1:0] model_read(input int addr, input logic we, input int waddr,
                                                    input logic [WIDTH-1:0] wd, input logic [NB-1:0] be);
        logic [WIDTH-1:0] v;
        v = model[addr];
`ifdef RAM_NR1W_BYPASS_EN
        if (we && addr == waddr) v = (v & ~byte_mask(be)) | (wd & byte_mask(be));
`endif
        return v;
    endfunction

    task automatic model_write(input logic we, input int waddr, input logic [WIDTH-1:0] wd,
                               input logic [NB-1:0] be);
        if (we) model[waddr] = (model[waddr] & ~byte_mask(be)) | (wd & byte_mask(be));
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic apply_cycle(input logic we, input int waddr, input logic [WIDTH-1:0] wd,
                               input logic [NB-1:0] be, input int ra0, input int ra1);
        @(negedge clk);
        wr_en      = we;
        wr_addr    = waddr[LG_DEPTH-1:0];
        wr_data    = wd;
        wr_byte_en = be;
        rd_addr    = {ra1[LG_DEPTH-1:0], ra0[LG_DEPTH-1:0]};
        @(posedge clk);
        #1;
    endtask

    // Runs the sweep after reset release; optionally issues one write at cycle write_at.
    task automatic run_sweep(input int write_at, input int waddr, input int stop_at,
                             output int cycles, output int zero_bad);
        cycles   = 0;
        zero_bad = 0;
        while (cycles < stop_at) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rd_data !== '0) zero_bad++;
            if (init_busy !== 1'b1) break;
            wr_en      = (cycles == write_at);
            wr_addr    = waddr[LG_DEPTH-1:0];
            wr_data    = 64'hCAFE_F00D_1234_5678;
            wr_byte_en = '1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int cycles, zero_bad;
        logic [WIDTH-1:0] exp0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (init_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b, expected 1", init_busy);
        end
        tests_run++;
        if (rd_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rd_data: got %h, expected 0", rd_data);
        end
        rd_addr = {6'd60, 6'd60};
        reset_n = 1'b1;
        run_sweep(10, 2, 200, cycles, zero_bad);
        model_clear();
        tests_run++;
        if (cycles != 64) begin
            tests_failed++;
            $display("[TB] FAIL sweep_length: got %0d cycles, expected 64", cycles);
        end
        tests_run++;
        if (zero_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_rd_zero: got %0d nonzero samples, expected 0", zero_bad);
        end
        exp0 = model_read(2, 1'b0, 0, '0, '0);
        apply_cycle(1'b0, 0, '0, '0, 2, 63);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== exp0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_ignores_write: got %h, expected %h", rd_data[WIDTH-1:0], exp0);
        end
        tests_run++;
        if (rd_data[2*WIDTH-1:WIDTH] !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_last_entry: got %h, expected 0", rd_data[2*WIDTH-1:WIDTH]);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] exp_coll;
        apply_cycle(1'b1, 5, 64'h1122334455667788, 8'hFF, 0, 0);
        model_write(1'b1, 5, 64'h1122334455667788, 8'hFF);
        apply_cycle(1'b0, 0, '0, '0, 5, 5);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== 64'h1122334455667788) begin
            tests_failed++;
            $display("[TB] FAIL full_write_p0: got %h, expected 1122334455667788", rd_data[WIDTH-1:0]);
        end
        tests_run++;
        if (rd_data[2*WIDTH-1:WIDTH] !== 64'h1122334455667788) begin
            tests_failed++;
            $display("[TB] FAIL full_write_p1: got %h, expected 1122334455667788", rd_data[2*WIDTH-1:WIDTH]);
        end
        apply_cycle(1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 1);
        model_write(1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        apply_cycle(1'b1, 6, 64'h5555555555555555, 8'h00, 5, 5);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== 64'h11223344AAAAAAAA) begin
            tests_failed++;
            $display("[TB] FAIL partial_write: got %h, expected 11223344AAAAAAAA", rd_data[WIDTH-1:0]);
        end
        apply_cycle(1'b0, 0, '0, '0, 6, 6);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL zero_byte_en: got %h, expected 0", rd_data[WIDTH-1:0]);
        end
`ifdef RAM_NR1W_BYPASS_EN
        exp_coll = 64'h00000000000000FF;
`else
        exp_coll = 64'h0;
`endif
        apply_cycle(1'b1, 9, 64'hFFFFFFFFFFFFFFFF, 8'h01, 9, 9);
        model_write(1'b1, 9, 64'hFFFFFFFFFFFFFFFF, 8'h01);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== exp_coll || rd_data[2*WIDTH-1:WIDTH] !== exp_coll) begin
            tests_failed++;
            $display("[TB] FAIL collision: got %h, expected %h on both ports", rd_data, exp_coll);
        end
        apply_cycle(1'b0, 0, '0, '0, 9, 5);
        tests_run++;
        if (rd_data[WIDTH-1:0] !== 64'hFF) begin
            tests_failed++;
            $display("[TB] FAIL after_collision: got %h, expected ff", rd_data[WIDTH-1:0]);
        end
        apply_cycle(1'b1, 60, 64'h0000DEAD0000BEEF, 8'hFF, 0, 0);
        model_write(1'b1, 60, 64'h0000DEAD0000BEEF, 8'hFF);
    endtask

    task automatic test_random();
        logic             we;
        int               waddr, ra0, ra1;
        logic [WIDTH-1:0] wd, exp0, exp1;
        logic [NB-1:0]    be;
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = int'($urandom_range(0, 15));
            wd    = {$urandom, $urandom};
            be    = 8'($urandom);
            ra0   = int'($urandom_range(0, 15));
            ra1   = ($urandom_range(0, 3) == 0) ? ra0 : int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra0 = waddr;
            exp0  = model_read(ra0, we, waddr, wd, be);
            exp1  = model_read(ra1, we, waddr, wd, be);
            apply_cycle(we, waddr, wd, be, ra0, ra1);
            model_write(we, waddr, wd, be);
            tests_run++;
            if (rd_data[WIDTH-1:0] !== exp0) begin
                tests_failed++;
                $display("[TB] FAIL random_p0 n=%0d addr=%0d: got %h, expected %h", n, ra0, rd_data[WIDTH-1:0], exp0);
            end
            tests_run++;
            if (rd_data[2*WIDTH-1:WIDTH] !== exp1) begin
                tests_failed++;
                $display("[TB] FAIL random_p1 n=%0d addr=%0d: got %h, expected %h", n, ra1, rd_data[2*WIDTH-1:WIDTH], exp1);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cycles, zero_bad;
        @(negedge clk);
        rd_addr = {6'd60, 6'd60};
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_sweep(10, 5, 30, cycles, zero_bad);
        tests_run++;
        if (cycles != 30 || init_busy !== 1'b1 || zero_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL first_sweep_part: got cycles=%0d busy=%b nonzero=%0d, expected 30/1/0", cycles, init_busy, zero_bad);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (init_busy !== 1'b1 || rd_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got busy=%b rd=%h, expected 1 and 0", init_busy, rd_data);
        end
        wr_en = 1'b1; wr_addr = 6'd61; wr_data = '1; wr_byte_en = '1;
        repeat (2) @(posedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_sweep(20, 3, 200, cycles, zero_bad);
        model_clear();
        tests_run++;
        if (cycles != 64) begin
            tests_failed++;
            $display("[TB] FAIL restart_length: got %0d cycles, expected 64", cycles);
        end
        tests_run++;
        if (zero_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL restart_rd_zero: got %0d nonzero samples, expected 0", zero_bad);
        end
        for (int k = 0; k < 3; k++) begin
            int a0, a1;
            a0 = (k == 0) ? 3 : (k == 1) ? 60 : 5;
            a1 = (k == 0) ? 61 : (k == 1) ? 9 : 0;
            apply_cycle(1'b0, 0, '0, '0, a0, a1);
            tests_run++;
            if (rd_data[WIDTH-1:0] !== model[a0] || rd_data[2*WIDTH-1:WIDTH] !== model[a1]) begin
                tests_failed++;
                $display("[TB] FAIL restart_cleared a=%0d/%0d: got %h, expected 0", a0, a1, rd_data);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_en      = 1'b0;
        wr_byte_en = '0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
